// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: evaluates branches and jumps, checks the fetch prediction,
// registers the redirect, and keeps a 2-bit saturating-counter BHT with a combinational fetch lookup.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    input  logic             stall,
    input  logic             flush_in,
    input  logic [5:0]       aluSelect,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    output logic             valid_out,
    output logic             branch_taken,
    output logic [XLEN-1:0]  target,
    output logic [XLEN-1:0]  link,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_JALR = 6'b000100;
    localparam logic [5:0] OP_BEQ  = 6'b000101;
    localparam logic [5:0] OP_BNE  = 6'b000110;
    localparam logic [5:0] OP_BLT  = 6'b000111;
    localparam logic [5:0] OP_BGE  = 6'b001000;
    localparam logic [5:0] OP_BLTU = 6'b001001;
    localparam logic [5:0] OP_BGEU = 6'b001010;

    logic             w_is_br;
    logic             w_is_ctrl;
    logic             w_taken;
    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_pc_imm;
    logic [XLEN-1:0]  w_rs1_imm;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_next_pc;
    logic             w_mispredict;
    logic             w_cap;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_if_idx;
    logic [1:0]       w_bht_cur;
    logic [1:0]       w_bht_new;
    logic             w_unused;

    logic             r_valid;
    logic             r_taken;
    logic [XLEN-1:0]  r_target;
    logic [XLEN-1:0]  r_link;
    logic             r_mispredict;
    logic [XLEN-1:0]  r_redirect;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;
    logic [1:0]       r_bht [BHT_DEPTH];

    assign w_pc_plus4 = pc + XLEN'(4);
    assign w_pc_imm   = pc + imm;
    assign w_rs1_imm  = rs1 + imm;

    always_comb begin
        w_is_br   = 1'b0;
        w_is_ctrl = 1'b1;
        w_taken   = 1'b0;
        w_target  = w_pc_imm;
        case (aluSelect)
            OP_JAL:  w_taken = 1'b1;
            OP_JALR: begin
                w_taken  = 1'b1;
                w_target = {w_rs1_imm[XLEN-1:1], 1'b0};
            end
            OP_BEQ:  begin w_is_br = 1'b1; w_taken = (rs1 == rs2); end
            OP_BNE:  begin w_is_br = 1'b1; w_taken = (rs1 != rs2); end
            OP_BLT:  begin w_is_br = 1'b1; w_taken = ($signed(rs1) <  $signed(rs2)); end
            OP_BGE:  begin w_is_br = 1'b1; w_taken = ($signed(rs1) >= $signed(rs2)); end
            OP_BLTU: begin w_is_br = 1'b1; w_taken = (rs1 <  rs2); end
            OP_BGEU: begin w_is_br = 1'b1; w_taken = (rs1 >= rs2); end
            default: begin
                w_is_ctrl = 1'b0;
                w_target  = w_pc_plus4;
            end
        endcase
    end

    assign w_next_pc    = w_taken ? w_target : w_pc_plus4;
    assign w_mispredict = (pred_taken != w_taken) | (w_taken & (pred_target != w_target));
    assign w_cap        = valid_in & ~stall & ~flush_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid       <= 1'b0;
            r_taken       <= 1'b0;
            r_target      <= '0;
            r_link        <= '0;
            r_mispredict  <= 1'b0;
            r_redirect    <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (flush_in) begin
            r_valid      <= 1'b0;
            r_mispredict <= 1'b0;
        end else if (!stall) begin
            if (valid_in) begin
                r_valid       <= 1'b1;
                r_taken       <= w_taken;
                r_target      <= w_target;
                r_link        <= w_pc_plus4;
                r_mispredict  <= w_mispredict;
                r_redirect    <= w_next_pc;
                r_branch_cnt  <= r_branch_cnt + CNT_W'(w_is_ctrl);
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(w_mispredict);
            end else begin
                r_valid      <= 1'b0;
                r_mispredict <= 1'b0;
            end
        end
    end

    // BHT: only conditional branches train; the fetch lookup sees the pre-update value.
    assign w_idx     = pc[IDX_W+1:2];
    assign w_if_idx  = if_pc[IDX_W+1:2];
    assign w_bht_cur = r_bht[w_idx];

    always_comb begin
        w_bht_new = w_bht_cur;
        if (w_taken) begin
            if (w_bht_cur != 2'b11) w_bht_new = w_bht_cur + 2'd1;
        end else begin
            if (w_bht_cur != 2'b00) w_bht_new = w_bht_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
        end else if (w_cap && w_is_br) begin
            r_bht[w_idx] <= w_bht_new;
        end
    end

    assign w_unused = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

    assign if_pred_taken  = r_bht[w_if_idx][1];
    assign valid_out      = r_valid;
    assign branch_taken   = r_taken;
    assign target         = r_target;
    assign link           = r_link;
    assign mispredict     = r_mispredict;
    assign redirect_pc    = r_redirect;
    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispred_cnt;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed vectors for resolution, prediction check,
// stall/flush behaviour, BHT training/saturation and asynchronous reset.
module tb_branch_resolve_unit;
    logic        clk;
    logic        reset_n;
    logic        valid_in;
    logic        stall;
    logic        flush_in;
    logic [5:0]  aluSelect;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        valid_out;
    logic        branch_taken;
    logic [31:0] target;
    logic [31:0] link;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    int checks_reg = 0;
    int errors_reg = 0;

    branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(64), .CNT_W(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .valid_in       (valid_in),
        .stall          (stall),
        .flush_in       (flush_in),
        .aluSelect      (aluSelect),
        .pc             (pc),
        .rs1            (rs1),
        .rs2            (rs2),
        .imm            (imm),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .valid_out      (valid_out),
        .branch_taken   (branch_taken),
        .target         (target),
        .link           (link),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_reg++;
        if (obs !== exp) begin
            errors_reg++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one instruction, let one edge pass, sample 1 time unit later.
    task automatic send(input logic [5:0] op, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im, input logic pt,
                        input logic [31:0] ptg);
        aluSelect   = op;
        pc          = p;
        rs1         = a;
        rs2         = b;
        imm         = im;
        pred_taken  = pt;
        pred_target = ptg;
        valid_in    = 1'b1;
        @(posedge clk);
        #1;
        $display("txn op=%b pc=%h stall=%b flush=%b -> valid=%b taken=%b target=%h mp=%b redir=%h",
                 op, p, stall, flush_in, valid_out, branch_taken, target, mispredict, redirect_pc);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; valid_in = 1'b0; stall = 1'b0; flush_in = 1'b0;
        aluSelect = 6'd0; pc = '0; rs1 = '0; rs2 = '0; imm = '0;
        pred_taken = 1'b0; pred_target = '0; if_pc = 32'h100;
        tick(); tick();
        check("rst_valid",   valid_out, 0);
        check("rst_target",  target, 0);
        check("rst_bcnt",    branch_cnt, 0);
        check("rst_bht",     if_pred_taken, 0);
        reset_n = 1'b1;

        // BEQ taken, correctly predicted; BHT entry 0 goes 01 -> 10
        send(6'b000101, 32'h100, 32'd10, 32'd10, 32'h40, 1'b1, 32'h140);
        check("beq_valid",  valid_out, 1);
        check("beq_taken",  branch_taken, 1);
        check("beq_target", target, 32'h140);
        check("beq_link",   link, 32'h104);
        check("beq_mp",     mispredict, 0);
        check("beq_bcnt",   branch_cnt, 1);
        check("beq_bht",    if_pred_taken, 1);

        // BLT signed taken, predicted not-taken
        send(6'b000111, 32'h200, 32'hFFFF_FFF6, 32'd5, 32'hFFFF_FFF8, 1'b0, 32'h0);
        check("blt_taken", branch_taken, 1);
        check("blt_mp",    mispredict, 1);
        check("blt_redir", redirect_pc, 32'h1F8);
        check("blt_mcnt",  mispredict_cnt, 1);
        check("blt_bcnt",  branch_cnt, 2);

        // JALR with LSB clear
        send(6'b000100, 32'h300, 32'h1003, 32'h0, 32'h4, 1'b1, 32'h1006);
        check("jalr_target", target, 32'h1006);
        check("jalr_link",   link, 32'h304);
        check("jalr_mp",     mispredict, 0);
        check("jalr_bcnt",   branch_cnt, 3);

        valid_in = 1'b0;
        tick();
        check("idle_valid", valid_out, 0);
        check("idle_mp",    mispredict, 0);

        // BGEU held in stall for three cycles, then captured once
        if_pc = 32'h20;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(6'b001010, 32'h20, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
            check("stl_valid", valid_out, 0);
            check("stl_bcnt",  branch_cnt, 3);
            check("stl_bht",   if_pred_taken, 0);
        end
        stall = 1'b0;
        send(6'b001010, 32'h20, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
        check("bgeu_valid",  valid_out, 1);
        check("bgeu_taken",  branch_taken, 1);
        check("bgeu_target", target, 32'h30);
        check("bgeu_mp",     mispredict, 1);
        check("bgeu_bcnt",   branch_cnt, 4);
        check("bgeu_mcnt",   mispredict_cnt, 2);
        check("bgeu_bht",    if_pred_taken, 1);
        stall = 1'b1;
        send(6'b000101, 32'h20, 32'd0, 32'd1, 32'h10, 1'b1, 32'h0);
        check("hold_valid", valid_out, 1);
        check("hold_mp",    mispredict, 1);
        check("hold_mcnt",  mispredict_cnt, 2);
        flush_in = 1'b1;
        send(6'b001010, 32'h20, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
        check("flush_valid",  valid_out, 0);
        check("flush_mp",     mispredict, 0);
        check("flush_target", target, 32'h30);
        check("flush_bcnt",   branch_cnt, 4);
        flush_in = 1'b0;
        stall = 1'b0;

        // Four taken BNE saturate entry 4; a not-taken one leaves it weakly taken
        if_pc = 32'h10;
        for (int i = 0; i < 4; i++) begin
            send(6'b000110, 32'h10, 32'd1, 32'd2, 32'h8, 1'b1, 32'h18);
            check("bne_mp",  mispredict, 0);
            check("bne_bht", if_pred_taken, 1);
        end
        send(6'b000110, 32'h10, 32'd7, 32'd7, 32'h8, 1'b1, 32'h18);
        check("bnent_taken", branch_taken, 0);
        check("bnent_redir", redirect_pc, 32'h14);
        check("bnent_mp",    mispredict, 1);
        check("bnent_bht",   if_pred_taken, 1);
        check("bnent_bcnt",  branch_cnt, 9);

        // Non-control op predicted taken
        send(6'b111111, 32'h400, 32'd0, 32'd0, 32'h0, 1'b1, 32'h800);
        check("nc_mp",     mispredict, 1);
        check("nc_taken",  branch_taken, 0);
        check("nc_redir",  redirect_pc, 32'h404);
        check("nc_bcnt",   branch_cnt, 9);
        check("nc_mcnt",   mispredict_cnt, 4);

        // BGE signed: -1 >= 1 is false
        send(6'b001000, 32'h600, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h0);
        check("bge_taken", branch_taken, 0);
        check("bge_mp",    mispredict, 0);
        // BLTU unsigned: 1 < 0xFFFFFFFF
        send(6'b001001, 32'h700, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1, 32'h600);
        check("bltu_taken",  branch_taken, 1);
        check("bltu_target", target, 32'h600);
        check("bltu_mp",     mispredict, 0);
        // JAL with wrong predicted target
        send(6'b000011, 32'h500, 32'd0, 32'd0, 32'h20, 1'b1, 32'h524);
        check("jal_target", target, 32'h520);
        check("jal_mp",     mispredict, 1);
        check("jal_redir",  redirect_pc, 32'h520);

        // Asynchronous reset mid-cycle while stalled
        stall = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_valid",  valid_out, 0);
        check("arst_taken",  branch_taken, 0);
        check("arst_target", target, 0);
        check("arst_link",   link, 0);
        check("arst_redir",  redirect_pc, 0);
        check("arst_mp",     mispredict, 0);
        check("arst_bcnt",   branch_cnt, 0);
        check("arst_mcnt",   mispredict_cnt, 0);
        check("arst_bht10",  if_pred_taken, 0);
        if_pc = 32'h20;
        #1;
        check("arst_bht20",  if_pred_taken, 0);
        stall = 1'b0;
        #1;
        reset_n = 1'b1;

        // First edge after reset release captures
        send(6'b000101, 32'h100, 32'd3, 32'd3, 32'h40, 1'b0, 32'h0);
        check("post_valid", valid_out, 1);
        check("post_mp",    mispredict, 1);
        check("post_bcnt",  branch_cnt, 1);
        valid_in = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks_reg, errors_reg);
        $finish;
    end
endmodule
